// File: rtl/sftm_pkg.sv
// Shared types and elaboration helpers for the SFTM job scheduler.
package sftm_pkg;

   // Job phases in execution order; IDLE doubles as the "job finished" marker.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_COMPUTE,
      ST_DRAIN,
      ST_POST
   } sftm_state_e;

   // Ceiling of log2, usable in parameter and port-width expressions.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = 1; v < n; v = v * 2) r++;
      return r;
   endfunction

   // Index width that never collapses to zero bits.
   function automatic int idx_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   // Number of SCUs in the array.
   function automatic int nscu(input int pof, input int pif);
      return pof * pif;
   endfunction

   // ceil(value / 2**shift) as a shift plus a nonzero-remainder increment.
   function automatic int unsigned ceil_shift(input int unsigned value, input int unsigned shift);
      int unsigned mask;
      mask = (32'd1 << shift) - 32'd1;
      return (value >> shift) + (((value & mask) != 32'd0) ? 32'd1 : 32'd0);
   endfunction

   // Phase that follows a given phase; POST wraps to IDLE.
   function automatic sftm_state_e next_phase(input sftm_state_e s);
      case (s)
         ST_PRE:     return ST_COMPUTE;
         ST_COMPUTE: return ST_DRAIN;
         ST_DRAIN:   return ST_POST;
         default:    return ST_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/sftm_job_fifo.sv
// Synchronous first-word-fall-through FIFO holding {tag, loads} job entries.
module sftm_job_fifo
   import sftm_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [clog2(DEPTH):0]  count
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == (AW + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Entry storage write.
   // NOTE: the storage array has no reset; only pointers and count decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush && !rst) mem[wr_ptr] <= wr_data;
   end

   // Pointer and occupancy tracking; flush empties the queue in one edge.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sftm_job_scheduler.sv
// Queued SFTM job scheduler: FSM, phase counter, load reduction and completion reporting.
module sftm_job_scheduler
   import sftm_pkg::*;
#(
   parameter int POF                  = 2,
   parameter int PIF                  = 3,
   parameter int MULT_WIDTH           = 16,
   parameter int SCU_MULTIPLIERS      = 4,
   parameter int PRETU_LATENCY        = 2,
   parameter int SCU_PIPELINE_LATENCY = 1,
   parameter int POSTTU_LATENCY       = 2,
   parameter int JOB_DEPTH            = 4,
   parameter int TAG_WIDTH            = 4,
   parameter int CYC_WIDTH            = MULT_WIDTH + 1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     job_valid,
   output logic                                     job_ready,
   input  logic [nscu(POF, PIF)*MULT_WIDTH-1:0]     assigned_mults_flat,
   input  logic [TAG_WIDTH-1:0]                     job_tag,
   input  logic                                     start,
   input  logic                                     auto_run,
   input  logic                                     abort,
   output logic                                     busy,
   output logic                                     job_done,
   output logic [TAG_WIDTH-1:0]                     done_tag,
   output logic [CYC_WIDTH-1:0]                     done_cycles,
   output logic [idx_width(nscu(POF, PIF))-1:0]     done_max_scu,
   output logic [clog2(JOB_DEPTH):0]                queue_count
);

   localparam int NSCU      = nscu(POF, PIF);
   localparam int IDX_W     = idx_width(NSCU);
   localparam int LOAD_W    = NSCU * MULT_WIDTH;
   localparam int ENTRY_W   = TAG_WIDTH + LOAD_W;
   localparam int MUL_SHIFT = clog2(SCU_MULTIPLIERS);

   sftm_state_e          st, nxt_st, cand;
   logic [CYC_WIDTH-1:0] phase_cnt, nxt_cnt;
   logic                 launch, finish, found;

   logic [ENTRY_W-1:0]   head;
   logic [TAG_WIDTH-1:0] head_tag;
   logic [LOAD_W-1:0]    head_loads;
   logic                 fifo_full, fifo_empty, push;

   logic [CYC_WIDTH-1:0] scu_cyc, head_max_cyc;
   logic [IDX_W-1:0]     head_max_idx;

   logic [TAG_WIDTH-1:0] act_tag;
   logic [CYC_WIDTH-1:0] act_max_cyc;
   logic [IDX_W-1:0]     act_max_idx;

   assign job_ready  = !fifo_full && !rst;
   assign push       = job_valid && job_ready && !abort;
   assign head_tag   = head[ENTRY_W-1 -: TAG_WIDTH];
   assign head_loads = head[LOAD_W-1:0];

   sftm_job_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (JOB_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (abort),
      .push    (push),
      .wr_data ({job_tag, assigned_mults_flat}),
      .pop     (launch),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (queue_count)
   );

   // Length in cycles of a phase for the active job.
   function automatic logic [CYC_WIDTH-1:0] phase_len(input sftm_state_e s,
                                                       input logic [CYC_WIDTH-1:0] mc);
      case (s)
         ST_PRE:     return CYC_WIDTH'(PRETU_LATENCY);
         ST_COMPUTE: return mc;
         ST_DRAIN:   return CYC_WIDTH'(SCU_PIPELINE_LATENCY);
         ST_POST:    return CYC_WIDTH'(POSTTU_LATENCY);
         default:    return '0;
      endcase
   endfunction

   // Heaviest SCU of the head job (lowest index wins ties), evaluated as it is popped.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      scu_cyc      = '0;
      head_max_cyc = '0;
      head_max_idx = '0;
      for (int i = 0; i < NSCU; i++) begin
         scu_cyc = CYC_WIDTH'(ceil_shift(32'(head_loads[i*MULT_WIDTH +: MULT_WIDTH]), MUL_SHIFT));
         if (scu_cyc > head_max_cyc) begin
            head_max_cyc = scu_cyc;
            head_max_idx = IDX_W'(i);
         end
      end
   end

   // State register, phase counter and the per-job values captured at launch.
   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= ST_IDLE;
         phase_cnt   <= '0;
         act_tag     <= '0;
         act_max_cyc <= '0;
         act_max_idx <= '0;
      end else begin
         st        <= nxt_st;
         phase_cnt <= nxt_cnt;
         if (launch) begin
            act_tag     <= head_tag;
            act_max_cyc <= head_max_cyc;
            act_max_idx <= head_max_idx;
         end
      end
   end

   // Next state: count down the current phase, then skip forward past zero-length phases.
   always_comb begin
      nxt_st  = st;
      nxt_cnt = phase_cnt;
      launch  = 1'b0;
      finish  = 1'b0;
      cand    = st;
      found   = 1'b0;
      if (st == ST_IDLE) begin
         launch = !fifo_empty && (start || auto_run);
      end else if (phase_cnt != '0) begin
         nxt_cnt = phase_cnt - 1'b1;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (!found) begin
               cand  = next_phase(cand);
               found = (cand == ST_IDLE) || (phase_len(cand, act_max_cyc) != '0);
            end
         end
         if (cand == ST_IDLE) begin
            finish = 1'b1;
            nxt_st = ST_IDLE;
            launch = auto_run && !fifo_empty;
         end else begin
            nxt_st  = cand;
            nxt_cnt = phase_len(cand, act_max_cyc) - 1'b1;
         end
      end
      if (launch) begin
         nxt_st  = ST_PRE;
         nxt_cnt = CYC_WIDTH'(PRETU_LATENCY - 1);
      end
      if (abort) begin
         nxt_st  = ST_IDLE;
         nxt_cnt = '0;
         launch  = 1'b0;
         finish  = 1'b0;
      end
   end

   // Busy whenever a job occupies any phase.
   always_comb begin
      busy = (st != ST_IDLE);
   end

   // Completion pulse and the held report of the most recently finished job.
   always_ff @(posedge clk) begin
      if (rst) begin
         job_done     <= 1'b0;
         done_tag     <= '0;
         done_cycles  <= '0;
         done_max_scu <= '0;
      end else begin
         job_done <= finish;
         if (finish) begin
            done_tag     <= act_tag;
            done_cycles  <= CYC_WIDTH'(PRETU_LATENCY + SCU_PIPELINE_LATENCY + POSTTU_LATENCY)
                            + act_max_cyc;
            done_max_scu <= act_max_idx;
         end
      end
   end

endmodule

// File: tb/tb_sftm_job_scheduler.sv
// Scoreboard bench for sftm_job_scheduler with a queue-level reference model.
module tb_sftm_job_scheduler;

   localparam int NSCU  = 6;
   localparam int MW    = 16;
   localparam int MUL   = 4;
   localparam int PRE   = 2;
   localparam int SPL   = 1;
   localparam int POST  = 2;
   localparam int DEPTH = 4;
   localparam int TW    = 4;
   localparam int CW    = 17;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 job_valid = 1'b0;
   logic                 start = 1'b0;
   logic                 auto_run = 1'b0;
   logic                 abort = 1'b0;
   logic [NSCU*MW-1:0]   loads = '0;
   logic [TW-1:0]        tag = '0;
   logic                 job_ready, busy, job_done;
   logic [TW-1:0]        done_tag;
   logic [CW-1:0]        done_cycles;
   logic [2:0]           done_max_scu;
   logic [2:0]           queue_count;

   sftm_job_scheduler dut (
      .clk                 (clk),
      .rst                 (rst),
      .job_valid           (job_valid),
      .job_ready           (job_ready),
      .assigned_mults_flat (loads),
      .job_tag             (tag),
      .start               (start),
      .auto_run            (auto_run),
      .abort               (abort),
      .busy                (busy),
      .job_done            (job_done),
      .done_tag            (done_tag),
      .done_cycles         (done_cycles),
      .done_max_scu        (done_max_scu),
      .queue_count         (queue_count)
   );

   always #5 clk = ~clk;

   typedef struct { logic [TW-1:0] tag; logic [NSCU*MW-1:0] loads; } job_t;
   typedef struct { logic [TW-1:0] tag; int cyc; int idx; longint due; } exp_t;

   job_t   mq[$];
   exp_t   sb[$];
   bit     m_active = 1'b0;
   longint m_end = 0;
   longint edge_cnt = 0;
   int     checks = 0;
   int     errors = 0;
   int     hold_tag = 0, hold_cyc = 0, hold_idx = 0;
   bit     mon_en = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edge_cnt);
      end
   endtask

   // Expected report for a job from plain division and a max search.
   function automatic exp_t job_expect(input job_t j, input longint launch_edge);
      exp_t e;
      int   m, c, mx, ix;
      mx = 0;
      ix = 0;
      for (int i = 0; i < NSCU; i++) begin
         m = j.loads[i*MW +: MW];
         c = (m + MUL - 1) / MUL;
         if (c > mx) begin
            mx = c;
            ix = i;
         end
      end
      e.tag = j.tag;
      e.cyc = PRE + mx + SPL + POST;
      e.idx = ix;
      e.due = launch_edge + e.cyc;
      return e;
   endfunction

   // Reference model: one call per rising edge with the inputs the DUT sampled.
   task automatic model_step();
      bit   was_active, finishing, do_launch;
      int   sz;
      job_t j;
      exp_t e;
      if (rst) begin
         mq.delete();
         sb.delete();
         m_active = 1'b0;
         hold_tag = 0;
         hold_cyc = 0;
         hold_idx = 0;
         return;
      end
      if (abort) begin
         mq.delete();
         sb.delete();
         m_active = 1'b0;
         return;
      end
      was_active = m_active;
      finishing  = m_active && (edge_cnt == m_end);
      if (finishing) m_active = 1'b0;
      sz = mq.size();
      do_launch = (sz > 0) && (was_active ? (finishing && auto_run) : (start || auto_run));
      if (do_launch) begin
         j = mq.pop_front();
         e = job_expect(j, edge_cnt);
         sb.push_back(e);
         m_active = 1'b1;
         m_end    = e.due;
      end
      if (job_valid && sz < DEPTH) begin
         j.tag   = tag;
         j.loads = loads;
         mq.push_back(j);
      end
   endtask

   // Monitor: compare the completion pulse and held report, plus status outputs.
   always @(negedge clk) begin
      bit   exp_now;
      exp_t e;
      if (mon_en) begin
         exp_now = (sb.size() > 0) && (sb[0].due == edge_cnt);
         check("job_done", job_done, exp_now);
         if (exp_now) begin
            e = sb.pop_front();
            hold_tag = e.tag;
            hold_cyc = e.cyc;
            hold_idx = e.idx;
         end
         check("done_tag", done_tag, hold_tag);
         check("done_cycles", done_cycles, hold_cyc);
         check("done_max_scu", done_max_scu, hold_idx);
         check("busy", busy, m_active);
         check("queue_count", queue_count, mq.size());
         check("job_ready", job_ready, (!rst && mq.size() < DEPTH));
      end
   end

   task automatic tick();
      @(posedge clk);
      edge_cnt++;
      model_step();
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic enqueue(input logic [TW-1:0] t, input logic [NSCU*MW-1:0] l);
      job_valid = 1'b1;
      tag       = t;
      loads     = l;
      tick();
      job_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic drain(input int limit);
      int k;
      k = 0;
      while ((m_active || mq.size() > 0) && k < limit) begin
         tick();
         k++;
      end
      check("drain_bound", (m_active || mq.size() > 0), 0);
   endtask

   function automatic logic [NSCU*MW-1:0] pack6(input int a, b, c, d, e, f);
      logic [NSCU*MW-1:0] v;
      v = {MW'(f), MW'(e), MW'(d), MW'(c), MW'(b), MW'(a)};
      return v;
   endfunction

   initial begin
      logic [NSCU*MW-1:0] l1, heavy, big;
      l1    = pack6(1, 4, 7, 10, 13, 16);
      heavy = pack6(400, 400, 400, 400, 400, 400);
      big   = pack6(0, 0, 'hFFFF, 0, 0, 0);

      rst = 1'b1;
      tick();
      mon_en = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // Manual start, mixed loads: L = 9, heaviest SCU 4.
      enqueue(4'd1, l1);
      pulse_start();
      drain(50);
      run(2);

      // All-zero loads skip COMPUTE: L = 5.
      enqueue(4'd2, '0);
      pulse_start();
      drain(50);
      run(2);

      // Start with an empty queue is ignored.
      pulse_start();
      run(2);

      // Auto-run chaining of two identical jobs.
      enqueue(4'd3, l1);
      enqueue(4'd5, l1);
      auto_run = 1'b1;
      drain(60);
      auto_run = 1'b0;
      run(2);

      // Five back-to-back enqueues: the fifth is refused.
      for (int i = 0; i < 5; i++) enqueue(TW'(6 + i), pack6(i, 2 * i, 0, 3, i + 5, 1));
      auto_run = 1'b1;
      drain(200);
      auto_run = 1'b0;
      run(2);

      // Widest load on one SCU: L = 16389.
      enqueue(4'd11, big);
      pulse_start();
      drain(17000);
      run(2);

      // Abort mid-COMPUTE with two jobs queued, a new job offered in the abort cycle.
      enqueue(4'd12, heavy);
      enqueue(4'd13, heavy);
      enqueue(4'd14, heavy);
      pulse_start();
      run(10);
      abort     = 1'b1;
      job_valid = 1'b1;
      tag       = 4'd15;
      tick();
      abort     = 1'b0;
      job_valid = 1'b0;
      run(3);
      enqueue(4'd1, l1);
      pulse_start();
      drain(50);
      run(2);

      // Reset mid-COMPUTE with two jobs queued.
      enqueue(4'd12, heavy);
      enqueue(4'd13, heavy);
      enqueue(4'd14, heavy);
      pulse_start();
      run(10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run(3);
      enqueue(4'd9, l1);
      pulse_start();
      drain(50);
      run(2);

      // Randomised traffic with occasional aborts.
      for (int n = 0; n < 600; n++) begin
         job_valid = ($urandom_range(0, 2) == 0);
         tag       = TW'($urandom);
         for (int i = 0; i < NSCU; i++)
            loads[i*MW +: MW] = ($urandom_range(0, 3) == 0) ? '0 : MW'($urandom_range(0, 40));
         start    = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) auto_run = ~auto_run;
         abort    = ($urandom_range(0, 80) == 0);
         tick();
      end
      job_valid = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      auto_run  = 1'b1;
      drain(500);
      auto_run  = 1'b0;
      run(3);
      check("scoreboard_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sftm_job_scheduler.md
# sftm_job_scheduler

Parametrised successor to the single-job SFTM core controller. It accepts per-SCU multiplication loads into a JOB_DEPTH-deep queue and runs each job through the pre-transform, SCU compute, SCU pipeline drain and post-transform phases. Each job's duration is derived from its heaviest SCU. It adds tagged jobs, back-to-back auto-run, synchronous abort and per-job cycle/bottleneck reporting. It sits between the layer sequencer and the SCU array.

## Interface
- POF, 2, output-feature parallelism
- PIF, 3, input-feature parallelism; NSCU = POF*PIF
- MULT_WIDTH, 16, per-SCU load width
- SCU_MULTIPLIERS, 4, multipliers per SCU; must be a power of two ≥1
- PRETU_LATENCY, 2, pre-transform cycles; ≥1
- SCU_PIPELINE_LATENCY, 1, SCU drain cycles; ≥0
- POSTTU_LATENCY, 2, post-transform cycles; ≥0
- JOB_DEPTH, 4, queue entries; power of two ≥2
- TAG_WIDTH, 4, job tag width
- CYC_WIDTH, MULT_WIDTH+1, cycle-count width

Ports:
- clk  in  1  clock; one clock; reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- job_valid  in  1  enqueue request
- job_ready  out  1  = !full && !rst
- assigned_mults_flat  in  NSCU*MULT_WIDTH  SCU i load at [i*MULT_WIDTH +: MULT_WIDTH]
- job_tag  in  TAG_WIDTH  tag stored with the job
- start  in  1  launch head job (manual mode)
- auto_run  in  1  1 = launch queued jobs without start
- abort  in  1  flush queue and active job
- busy  out  1  job in flight
- job_done  out  1  one-cycle completion pulse
- done_tag  out  TAG_WIDTH  tag of the completed job
- done_cycles  out  CYC_WIDTH  L of the completed job
- done_max_scu  out  clog2(NSCU)  lowest index of the SCU with the maximum ceil load
- queue_count  out  clog2(JOB_DEPTH)+1  occupancy

## Operation
- Enqueue on job_valid && job_ready at a rising edge. When full, the job is refused even if a dequeue happens in the same cycle.
- Per-SCU cycles: c_i = ceil(m_i / SCU_MULTIPLIERS), computed as a shift plus a nonzero-remainder increment. No divider.
- Per-job values: max_cyc = max c_i. L = PRETU_LATENCY + max_cyc + SCU_PIPELINE_LATENCY + POSTTU_LATENCY.
- Compute max_cyc and done_max_scu at dequeue and register them with the job.
- FSM states: IDLE → PRE → COMPUTE → DRAIN → POST → IDLE. Each state lasts its latency in cycles. Zero-length states are skipped (max_cyc=0 skips COMPUTE).
- Launch from IDLE when the queue is non-empty and (start || auto_run). The launch pops the head entry.
- start with an empty queue, or while busy: ignored, not latched.
- On leaving POST: job_done=1 for one cycle; done_tag, done_cycles and done_max_scu update and hold until the next completion.
- Auto-run chaining: if auto_run=1 and the queue is non-empty on that same edge, the next job launches there. No IDLE bubble.
- abort takes priority over everything. Next edge: state IDLE, queue empty, busy=0, no job_done. A job_valid in the abort cycle is dropped.
- Reset values: busy=0, job_done=0, done_tag=0, done_cycles=0, done_max_scu=0, queue_count=0, job_ready=0 while rst is high.

## Timing
- E0 is the launch edge. busy=1 after E0. job_done=1 after edge E0+L and low after E0+L+1.
- busy falls with job_done unless chaining.
- Enqueue-to-launch minimum: a job enqueued at edge E can launch at E+1. Same-cycle bypass is not required.
- queue_count updates the edge after the push/pop. A simultaneous push and pop leaves it unchanged.
- Reset mid-job: all state clears at the reset edge and no job_done is produced.

## Structure
- Package sftm_pkg holds:
  - FSM state enum;
  - ceil_shift function;
  - clog2 helper;
  - NSCU derivation.
- Sub-module sftm_job_fifo: parametrised synchronous FIFO for {tag, loads}, with full, empty and count outputs.
- Top level holds the FSM, phase counter, max/argmax reduction and output registers.

## Test plan
- Loads 1,4,7,10,13,16, manual start → job_done 9 edges after launch; done_cycles=9; done_max_scu=4.
- All loads 0 → L=5 (COMPUTE skipped); done_max_scu=0.
- auto_run=1, two identical jobs (tags 3, 5) → pulses at E0+9 and E0+18; done_tag 3 then 5; busy continuously high.
- Enqueue 5 jobs back-to-back with no launch → first 4 accepted, job_ready=0 on the 5th, queue_count=4.
- Load 0xFFFF on SCU 2, SCU_MULTIPLIERS=4 → max_cyc=16384, done_cycles=16389.
- abort, then separately rst, mid-COMPUTE with 2 jobs queued → busy=0 and queue_count=0 next edge; no job_done; a fresh job afterwards completes normally.
